// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter runs 0..width-1, so $clog2(width) bits suffice for width >= 2.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand register, (2*WIDTH+1)-bit accumulator/shift register and held product register.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 capture,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    a_d       = a_q;
    acc_d     = acc_q;
    product_d = product_q;
    // acc_hi is W+1 bits wide so the carry out of the add survives the shift.
    sum       = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    if (load) begin
      a_d   = multiplicand;
      acc_d = {{(WIDTH+1){1'b0}}, multiplier};
    end else if (step) begin
      acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
    end

    // Capture the post-step value so the product lands on the same edge as the last step.
    if (capture) begin
      product_d = acc_d[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      a_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing FSM and step counter for the shift-and-add multiplier; drives busy/done.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, step, capture;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
          count_d = '0;
          done_d  = 1'b1;
          capture = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .capture      (capture),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and table-driven bench for seq_mult_ctrl at WIDTH=4.
module tb_seq_mult_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_prev;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             gap;
  } vec_t;

  vec_t vecs [10];

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One full operation: accept, wait for done with a bound, check latency and hold.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit disturb);
    int  lat;
    bit  held_ok;
    int  n_done;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done", done, 0);
    lat     = 0;
    held_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (disturb && i == 1) begin
        multiplicand = ~a;
        multiplier   = ~b;
        start        = 1'b1;
      end else if (disturb && i == 2) begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (busy !== 1'b1 || product !== exp_prev) held_ok = 1'b0;
    end
    start = 1'b0;
    check("latency", lat, W);
    check("hold_during_run", held_ok, 1);
    check("product", product, exp);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_hold", product, exp);
    exp_prev = exp;
    if (disturb) begin
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (done) n_done++;
      end
      check("no_extra_done", n_done, 0);
      check("disturb_hold", product, exp);
    end
  endtask

  initial begin
    vecs[0] = '{a: 4'h7, b: 4'h6, prod: 8'h2A, gap: 0};
    vecs[1] = '{a: 4'hF, b: 4'hF, prod: 8'hE1, gap: 1};
    vecs[2] = '{a: 4'h0, b: 4'hB, prod: 8'h00, gap: 0};
    vecs[3] = '{a: 4'hB, b: 4'hD, prod: 8'h8F, gap: 2};
    vecs[4] = '{a: 4'hF, b: 4'h1, prod: 8'h0F, gap: 0};
    vecs[5] = '{a: 4'h8, b: 4'h8, prod: 8'h40, gap: 3};
    vecs[6] = '{a: 4'hA, b: 4'h0, prod: 8'h00, gap: 0};
    vecs[7] = '{a: 4'h1, b: 4'hF, prod: 8'h0F, gap: 1};
    vecs[8] = '{a: 4'h9, b: 4'h9, prod: 8'h51, gap: 0};
    vecs[9] = '{a: 4'hC, b: 4'h5, prod: 8'h3C, gap: 2};

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    exp_prev     = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    for (int i = 0; i < 3; i++) tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_product", product, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0);
      for (int g = 0; g < vecs[i].gap; g++) tick();
    end

    // Operand changes and a stray start during RUN must not disturb the result.
    run_op(4'h3, 4'h5, 8'h0F, 1'b1);

    // start held high: done every W+2 cycles.
    begin
      int pulse_at [3];
      int n = 0;
      multiplicand = 4'h1;
      multiplier   = 4'h1;
      start        = 1'b1;
      for (int c = 1; c <= 40 && n < 3; c++) begin
        tick();
        if (done) begin
          pulse_at[n] = c;
          n++;
          check("held_product", product, 8'h01);
          if (n == 3) start = 1'b0;
        end
      end
      start = 1'b0;
      check("held_pulses", n, 3);
      if (n == 3) begin
        check("held_period_1", pulse_at[1] - pulse_at[0], W + 2);
        check("held_period_2", pulse_at[2] - pulse_at[1], W + 2);
      end
      tick();
      check("held_idle", busy, 0);
      exp_prev = 8'h01;
    end

    // Reset in the second RUN cycle aborts and clears the product.
    begin
      int n_done = 0;
      multiplicand = 4'h9;
      multiplier   = 4'h9;
      start        = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort_pre_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_product", product, 0);
      for (int i = 0; i < 8; i++) begin
        tick();
        if (done) n_done++;
      end
      check("abort_no_done", n_done, 0);
      exp_prev = '0;
    end

    // reset and start on the same edge: reset wins.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_wins_busy", busy, 0);
    tick();
    check("reset_wins_idle", busy, 0);

    // Exhaustive sweep against the bench's own multiply.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [W-1:0]   av, bv;
        logic [2*W-1:0] pv;
        av = W'(a);
        bv = W'(b);
        pv = (2*W)'(a * b);
        run_op(av, bv, pv, 1'b0);
        repeat ($urandom_range(0, 3)) tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
